mac_seq: RTL



---
 rtl/mac_pkg.sv | 19 +
 rtl/mac_feedback.sv | 40 ++++
 rtl/mac_seq.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// Shared constants for the mac sequencer: default widths, FSM encoding, mac latency.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mac_pkg;

   localparam int A_BITWIDTH_DEF   = 8;
   localparam int OUT_BITWIDTH_DEF = 19;
   localparam int LEN_BITWIDTH_DEF = 5;

   // Internal pipeline depth of the attached mac, from en to done.
   localparam int MAC_LATENCY = 3;

   // Sequencer state encoding.
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_ISSUE = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/mac_feedback.sv
// mac_feedback: maps the running sum onto the mac addend port; build option MAC_SEQ_SAT_EN selects clamping.
// Latency: combinational.
// Backpressure: none; pure function of acc_i.
module mac_feedback
   import mac_pkg::*;
#(
   parameter int OUT_BITWIDTH = OUT_BITWIDTH_DEF,
   parameter int C_BITWIDTH   = OUT_BITWIDTH - 1
) (
   input  logic [OUT_BITWIDTH-1:0] acc_i,
   output logic [C_BITWIDTH-1:0]   c_o,
   output logic                    clamp_o
);

`ifdef MAC_SEQ_SAT_EN
   // Largest and smallest values representable on the C_BITWIDTH addend, sign-extended to acc width.
   localparam logic [OUT_BITWIDTH-1:0] C_MAX = {{(OUT_BITWIDTH-C_BITWIDTH+1){1'b0}}, {(C_BITWIDTH-1){1'b1}}};
   localparam logic [OUT_BITWIDTH-1:0] C_MIN = {{(OUT_BITWIDTH-C_BITWIDTH+1){1'b1}}, {(C_BITWIDTH-1){1'b0}}};

   // Clamp the running sum into addend range and flag when it had to.
   always_comb begin
      c_o     = acc_i[C_BITWIDTH-1:0];
      clamp_o = 1'b0;
      if ($signed(acc_i) > $signed(C_MAX)) begin
         c_o     = C_MAX[C_BITWIDTH-1:0];
         clamp_o = 1'b1;
      end else if ($signed(acc_i) < $signed(C_MIN)) begin
         c_o     = C_MIN[C_BITWIDTH-1:0];
         clamp_o = 1'b1;
      end
   end
`else
   // Plain two's-complement wrap: the upper acc bits are simply dropped.
   logic unused_acc_hi;
   assign unused_acc_hi = ^acc_i[OUT_BITWIDTH-1:C_BITWIDTH];
   assign c_o           = acc_i[C_BITWIDTH-1:0];
   assign clamp_o       = 1'b0;
`endif

endmodule

// File: rtl/mac_seq.sv
// mac_seq: en/done initiator that runs a biased signed dot product through one mac (option MAC_SEQ_SAT_EN clamps feedback).
// Latency: 1 fetch + 4 issue cycles per pair with a 3-cycle mac; result_valid in cycle 5*len+1 (len==0: cycle 1).
// Backpressure: in_ready only while fetching; in_valid low there stalls indefinitely with no side effects.
module mac_seq
   import mac_pkg::*;
#(
   parameter int A_BITWIDTH   = A_BITWIDTH_DEF,
   parameter int B_BITWIDTH   = A_BITWIDTH,
   parameter int OUT_BITWIDTH = OUT_BITWIDTH_DEF,
   parameter int C_BITWIDTH   = OUT_BITWIDTH - 1,
   parameter int LEN_BITWIDTH = LEN_BITWIDTH_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [LEN_BITWIDTH-1:0] len,
   input  logic [C_BITWIDTH-1:0]   bias,
   output logic                    busy,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [A_BITWIDTH-1:0]   in_a,
   input  logic [B_BITWIDTH-1:0]   in_b,
   output logic                    mac_en,
   output logic [A_BITWIDTH-1:0]   mac_a,
   output logic [B_BITWIDTH-1:0]   mac_b,
   output logic [C_BITWIDTH-1:0]   mac_c,
   input  logic [OUT_BITWIDTH-1:0] mac_mout,
   input  logic                    mac_done,
   output logic [OUT_BITWIDTH-1:0] result,
   output logic                    result_valid,
   output logic                    sat_flag
);

   logic [1:0]              state_q,  state_d;
   logic [LEN_BITWIDTH-1:0] cnt_q,    cnt_d;
   logic [OUT_BITWIDTH-1:0] acc_q,    acc_d;
   logic [A_BITWIDTH-1:0]   mac_a_q,  mac_a_d;
   logic [B_BITWIDTH-1:0]   mac_b_q,  mac_b_d;
   logic                    mac_en_q, mac_en_d;
   logic                    busy_q,   busy_d;
   logic [OUT_BITWIDTH-1:0] result_q, result_d;
   logic                    rv_q,     rv_d;
   logic                    sat_q,    sat_d;
   logic                    clamp;

   mac_feedback #(
      .OUT_BITWIDTH (OUT_BITWIDTH),
      .C_BITWIDTH   (C_BITWIDTH)
   ) u_feedback (
      .acc_i   (acc_q),
      .c_o     (mac_c),
      .clamp_o (clamp)
   );

   // Next-state logic. result and its valid pulse are loaded on the transition
   // into DONE so the pulse and the data appear together in the DONE cycle.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      mac_a_d  = mac_a_q;
      mac_b_d  = mac_b_q;
      mac_en_d = mac_en_q;
      busy_d   = busy_q;
      result_d = result_q;
      rv_d     = 1'b0;
      sat_d    = sat_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               cnt_d  = len;
               acc_d  = {{(OUT_BITWIDTH-C_BITWIDTH){bias[C_BITWIDTH-1]}}, bias};
               sat_d  = 1'b0;
               busy_d = 1'b1;
               if (len == '0) begin
                  result_d = {{(OUT_BITWIDTH-C_BITWIDTH){bias[C_BITWIDTH-1]}}, bias};
                  rv_d     = 1'b1;
                  state_d  = ST_DONE;
               end else begin
                  state_d  = ST_FETCH;
               end
            end
         end
         ST_FETCH: begin
            if (in_valid) begin
               mac_a_d  = in_a;
               mac_b_d  = in_b;
               mac_en_d = 1'b1;
               state_d  = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            // acc is stable throughout ISSUE, so the clamp seen here is the one the mac uses.
            if (clamp) begin
               sat_d = 1'b1;
            end
            if (mac_done) begin
               acc_d    = mac_mout;
               cnt_d    = cnt_q - LEN_BITWIDTH'(1);
               mac_en_d = 1'b0;
               if (cnt_q == LEN_BITWIDTH'(1)) begin
                  result_d = mac_mout;
                  rv_d     = 1'b1;
                  state_d  = ST_DONE;
               end else begin
                  state_d  = ST_FETCH;
               end
            end
         end
         default: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers; reset aborts any command in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         mac_a_q  <= '0;
         mac_b_q  <= '0;
         mac_en_q <= 1'b0;
         busy_q   <= 1'b0;
         result_q <= '0;
         rv_q     <= 1'b0;
         sat_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         mac_a_q  <= mac_a_d;
         mac_b_q  <= mac_b_d;
         mac_en_q <= mac_en_d;
         busy_q   <= busy_d;
         result_q <= result_d;
         rv_q     <= rv_d;
         sat_q    <= sat_d;
      end
   end

   assign in_ready     = (state_q == ST_FETCH);
   assign busy         = busy_q;
   assign mac_en       = mac_en_q;
   assign mac_a        = mac_a_q;
   assign mac_b        = mac_b_q;
   assign result       = result_q;
   assign result_valid = rv_q;
   // Without clamping, clamp is constant 0 and sat_q never leaves reset.
   assign sat_flag     = sat_q;

endmodule
